// File: rtl/glitch_free_clkdiv_mux.sv
// N-channel programmable clock divider with a glitch-free channel selector (single clock domain).
// Define GLITCH_FREE_CLKDIV_GAP_EN to insert GAP_CYCLES extra low cycles on every channel switch.
module glitch_free_clkdiv_mux #(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 8,
  parameter int SEL_W      = $clog2(CHANNELS),
  parameter int GAP_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] div_table,
  output logic                      clk_out,
  output logic                      clk_en,
  output logic [SEL_W-1:0]          active_sel,
  output logic                      busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH
`ifdef GLITCH_FREE_CLKDIV_GAP_EN
    ,
    S_GAP
`endif
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] cnt_reg;
  logic [WIDTH-1:0] cur_div_reg;
  logic [SEL_W-1:0] active_sel_reg;
  logic             clk_out_reg;
  logic             clk_en_reg;
  logic             busy_reg;

`ifdef GLITCH_FREE_CLKDIV_GAP_EN
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  logic [GAP_W-1:0] gap_cnt_reg;
`endif

  logic [WIDTH-1:0] div_arr [CHANNELS];
  logic             sel_valid;
  logic             switch_req;

  if (CHANNELS < 2 || GAP_CYCLES < 1) begin : g_param_check
    $error("glitch_free_clkdiv_mux: CHANNELS must be >= 2 and GAP_CYCLES >= 1");
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_div
      assign div_arr[gi] = div_table[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Only non-power-of-two channel counts can see an out-of-range select.
  if ((1 << SEL_W) > CHANNELS) begin : g_sel_range
    assign sel_valid = (int'(sel) < CHANNELS);
  end else begin : g_sel_full
    assign sel_valid = 1'b1;
  end

  assign switch_req = sel_valid && (sel != active_sel_reg);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= '0;
      cur_div_reg    <= '0;
      active_sel_reg <= '0;
      clk_out_reg    <= 1'b0;
      clk_en_reg     <= 1'b0;
      busy_reg       <= 1'b0;
`ifdef GLITCH_FREE_CLKDIV_GAP_EN
      gap_cnt_reg    <= '0;
`endif
    end else begin
      clk_en_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          clk_out_reg <= 1'b0;
          busy_reg    <= 1'b0;
          if (en) begin
            state_reg <= S_LOW;
            cnt_reg   <= '0;
            // Output is already low, so a pending switch can be taken immediately.
            if (switch_req) begin
              active_sel_reg <= sel;
              cur_div_reg    <= div_arr[sel];
            end else begin
              cur_div_reg    <= div_arr[active_sel_reg];
            end
          end
        end

        S_LOW: begin
          busy_reg <= switch_req;
          if (cnt_reg == cur_div_reg) begin
            state_reg   <= S_HIGH;
            clk_out_reg <= 1'b1;
            clk_en_reg  <= 1'b1;
            cnt_reg     <= '0;
            cur_div_reg <= div_arr[active_sel_reg];
          end else begin
            cnt_reg <= cnt_reg + WIDTH'(1);
          end
        end

        S_HIGH: begin
          busy_reg <= switch_req;
          if (cnt_reg == cur_div_reg) begin
            clk_out_reg <= 1'b0;
            cnt_reg     <= '0;
            if (!en) begin
              state_reg <= S_IDLE;
              busy_reg  <= 1'b0;
            end else if (switch_req) begin
              // Falling edge: the only safe point to change the divisor source.
              active_sel_reg <= sel;
              cur_div_reg    <= div_arr[sel];
`ifdef GLITCH_FREE_CLKDIV_GAP_EN
              state_reg      <= S_GAP;
              busy_reg       <= 1'b1;
              gap_cnt_reg    <= '0;
`else
              state_reg      <= S_LOW;
              busy_reg       <= 1'b0;
`endif
            end else begin
              state_reg   <= S_LOW;
              cur_div_reg <= div_arr[active_sel_reg];
            end
          end else begin
            cnt_reg <= cnt_reg + WIDTH'(1);
          end
        end

`ifdef GLITCH_FREE_CLKDIV_GAP_EN
        S_GAP: begin
          clk_out_reg <= 1'b0;
          busy_reg    <= 1'b1;
          if (!en) begin
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
          end else if (gap_cnt_reg == GAP_LAST) begin
            state_reg   <= S_LOW;
            cnt_reg     <= '0;
            busy_reg    <= 1'b0;
            cur_div_reg <= div_arr[active_sel_reg];
          end else begin
            gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
          end
        end
`endif

        default: begin
          state_reg   <= S_IDLE;
          clk_out_reg <= 1'b0;
          busy_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign clk_out    = clk_out_reg;
  assign clk_en     = clk_en_reg;
  assign active_sel = active_sel_reg;
  assign busy       = busy_reg;

endmodule

// File: doc/glitch_free_clkdiv_mux.md
Name: glitch_free_clkdiv_mux

Overview:
- Single-clock, N-channel programmable clock divider with a glitch-free channel selector.
- Produces a divided clock whose half-period comes from one of CHANNELS runtime divisor entries.
- Channel switches are applied only at a falling edge of the output. Neither the old nor the new divisor can produce a runt high or low phase.
- Serves as the parametrised successor to the two-clock glitch-free mux. It feeds I2C/BERT bit-rate generators from the single system clock.

Parameters:
- CHANNELS, 4, number of selectable divisor entries (≥2).
- WIDTH, 8, width of each divisor entry and of the phase counter.
- SEL_W, $clog2(CHANNELS), width of sel and active_sel.
- GAP_CYCLES, 2, extra low cycles inserted on a switch (used only when the optional feature is enabled; ≥1).

Ports:
- clk  input  1  system clock; every register samples on its rising edge.
- reset  input  1  synchronous active-high reset.
- en  input  1  run request. Low means stop after the current high phase completes.
- sel  input  SEL_W  requested channel. Values ≥CHANNELS are ignored.
- div_table  input  CHANNELS*WIDTH  packed divisors, ch0 in the LSBs. Half-period H = div+1 clk cycles.
- clk_out  output  1  registered divided clock.
- clk_en  output  1  one-cycle strobe, high in the first cycle clk_out is high.
- active_sel  output  SEL_W  channel currently driving clk_out.
- busy  output  1  high while a channel switch is pending or in progress.

Behaviour:
- Reset (synchronous): state=IDLE, clk_out=0, clk_en=0, active_sel=0, busy=0, cnt=0, cur_div=0, pending cleared. Reset wins over all other events, including mid-phase.
- Clock and reset are fixed as decided: one clock, synchronous active-high reset, ports named clk and reset.
- FSM states: IDLE, LOW, HIGH, GAP (GAP exists only with the optional feature).
- IDLE:
  - clk_out=0.
  - When en=1 at an edge: go to LOW, cnt←0, cur_div←div_table[active_sel].
  - If sel is valid and differs from active_sel, first set active_sel←sel. The switch is free in IDLE because clk_out is already low.
- LOW:
  - If cnt==cur_div: go to HIGH, clk_out←1, clk_en←1 for one cycle, cnt←0, cur_div←div_table[active_sel].
  - Otherwise cnt←cnt+1.
  - Result: the low phase lasts exactly H cycles after LOW entry.
- HIGH:
  - If cnt!=cur_div: cnt←cnt+1.
  - If cnt==cur_div: clk_out←0 (falling edge), cnt←0, then take the first matching case:
    - en=0: go to IDLE. The high phase was already completed in full.
    - switch pending (sel valid and ≠active_sel): active_sel←sel, busy←0, cur_div←div_table[sel], go to LOW (or GAP, see Optional Feature).
    - otherwise: go to LOW with cur_div←div_table[active_sel].
- Divisor latching: cur_div is latched only at phase start. Changes to div_table mid-phase take effect at the next phase boundary, never mid-phase.
- busy:
  - Set the cycle after a valid sel≠active_sel is seen in LOW or HIGH.
  - Cleared when the switch is applied.
  - If sel returns to active_sel before the falling edge, the request is cancelled and busy clears.
- Invalid sel (≥CHANNELS): ignored. No request is raised and active_sel is unchanged.
- div=0 gives H=1, so clk_out=clk/2 with 50% duty. Period is always 2H; duty is always 50% except across a switch.
- Guarantee at every transition: each high phase lasts exactly H_old cycles, and each low phase lasts ≥ H_new cycles.

Optional Feature:
- Macro: GLITCH_FREE_CLKDIV_GAP_EN.
- Defined:
  - A channel switch goes HIGH→GAP with clk_out=0 and busy held high.
  - GAP runs for GAP_CYCLES cycles, then enters LOW with cnt=0.
  - The low phase across a switch is therefore GAP_CYCLES+H_new.
  - en=0 during GAP goes to IDLE.
- Undefined: the GAP state and GAP_CYCLES logic are absent; switches go directly to LOW.

Test Plan:
All cases use CHANNELS=4, WIDTH=8, div_table = ch0=0, ch1=1, ch2=3, ch3=7.
- Reset, then en=1, sel=0 → clk_out rises 1 cycle after LOW entry and toggles every cycle (period 2). clk_en pulses once per period. active_sel=0.
- Running ch1, sel→2 asserted mid-high phase → high phase completes its full 2 cycles. active_sel=2 at the falling edge. Then low 4, high 4. busy is high from request to falling edge. No phase shorter than 2.
- Running ch3, en→0 one cycle into high → high lasts 8 cycles, clk_out=0, state IDLE. Re-assert en → clk_out rises exactly 8 cycles after LOW entry.
- Running ch2, div_table ch2 changed 3→1 mid-phase → current phase stays 4 cycles; following phases are 2 cycles.
- reset asserted mid-high on ch3 → clk_out=0, clk_en=0, active_sel=0, busy=0 on the next cycle. sel=7-equivalent invalid input with CHANNELS=3 build → active_sel unchanged, busy stays 0.
- With GLITCH_FREE_CLKDIV_GAP_EN and GAP_CYCLES=2, switch ch0→ch1 → low phase after the switching fall is 2+2=4 cycles, busy is high throughout GAP, then period 4.
